// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA precompute scheduler: FSM states, engine
// operation codes and default sizing.
package rsa_pkg;

  localparam int W_DEF   = 4096;
  localparam int TMO_DEF = 1048575;

  localparam logic OP_R = 1'b0;
  localparam logic OP_T = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_GO_R,
    S_WAIT_R,
    S_GO_T,
    S_WAIT_T,
    S_RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the priority pointer toggles on every
// accepted grant, and a lone requester always wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = ~ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mod_precomp_sched.sv
// Schedules Montgomery precompute (R mod n, R^2 mod n) for two requesters
// onto one shared engine, with a single-entry result cache and timeout.
module mod_precomp_sched
  import rsa_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_n,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_n,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r,
  output logic [W-1:0] rsp_r2,
  output logic         rsp_err,
  input  logic         rsp_ready,
  output logic         eng_go,
  output logic         eng_mode,
  output logic [W-1:0] eng_n,
  input  logic [W-1:0] eng_r,
  input  logic         eng_done
);

  localparam int CW = $clog2(TMO + 1);

  state_t         state_q, state_d;
  logic [W-1:0]   n_q, n_d;
  logic           mode_q, mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cv_q, cv_d;
  logic [W-1:0]   cn_q, cn_d;
  logic [W-1:0]   cr_q, cr_d;
  logic [W-1:0]   cr2_q, cr2_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_r_q, rsp_r_d;
  logic [W-1:0]   rsp_r2_q, rsp_r2_d;
  logic           rsp_err_q, rsp_err_d;

  logic [1:0]     gnt;
  logic           grant;
  logic [W-1:0]   win_n;
  logic           hit;
  logic           done_ok;
  logic           tmo_hit;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1_valid, req0_valid}),
    .adv   (grant),
    .gnt   (gnt)
  );

  assign grant   = (state_q == S_ARB) && (gnt != 2'b00);
  assign win_n   = gnt[1] ? req1_n : req0_n;
  assign hit     = cv_q && (cn_q == win_n);
  // eng_done is a held level; the first two wait cycles may still show the previous job's done.
  assign done_ok = (cnt_q >= CW'(2)) && eng_done;
  assign tmo_hit = (cnt_q == CW'(TMO - 1));

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    cv_d      = cv_q;
    cn_d      = cn_q;
    cr_d      = cr_q;
    cr2_d     = cr2_q;
    rsp_id_d  = rsp_id_q;
    rsp_r_d   = rsp_r_q;
    rsp_r2_d  = rsp_r2_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (grant) begin
          n_d       = win_n;
          rsp_id_d  = gnt[1];
          rsp_err_d = 1'b0;
          if (hit) begin
            rsp_r_d  = cr_q;
            rsp_r2_d = cr2_q;
            state_d  = S_RESP;
          end else begin
            mode_d  = OP_R;
            state_d = S_GO_R;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GO_R, S_GO_T: begin
        cnt_d   = '0;
        state_d = (state_q == S_GO_R) ? S_WAIT_R : S_WAIT_T;
      end
      S_WAIT_R, S_WAIT_T: begin
        if (done_ok) begin
          if (state_q == S_WAIT_R) begin
            rsp_r_d = eng_r;
            mode_d  = OP_T;
            state_d = S_GO_T;
          end else begin
            rsp_r2_d = eng_r;
            cv_d     = 1'b1;
            cn_d     = n_q;
            cr_d     = rsp_r_q;
            cr2_d    = eng_r;
            state_d  = S_RESP;
          end
        end else if (tmo_hit) begin
          rsp_r_d   = '0;
          rsp_r2_d  = '0;
          rsp_err_d = 1'b1;
          cv_d      = 1'b0;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      mode_q    <= OP_R;
      cnt_q     <= '0;
      cv_q      <= 1'b0;
      cn_q      <= '0;
      cr_q      <= '0;
      cr2_q     <= '0;
      rsp_id_q  <= 1'b0;
      rsp_r_q   <= '0;
      rsp_r2_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      cv_q      <= cv_d;
      cn_q      <= cn_d;
      cr_q      <= cr_d;
      cr2_q     <= cr2_d;
      rsp_id_q  <= rsp_id_d;
      rsp_r_q   <= rsp_r_d;
      rsp_r2_q  <= rsp_r2_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req0_ready = grant && gnt[0];
  assign req1_ready = grant && gnt[1];
  assign eng_go     = (state_q == S_GO_R) || (state_q == S_GO_T);
  assign eng_mode   = mode_q;
  assign eng_n      = n_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_r      = rsp_r_q;
  assign rsp_r2     = rsp_r2_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_mod_precomp_sched.sv
// Bench for mod_precomp_sched at W=16/TMO=100 with a behavioural modulus
// engine and a transaction-level model of cache, arbitration and results.
module tb_mod_precomp_sched;

  localparam int W   = 16;
  localparam int TMO = 100;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_n, req1_n;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [W-1:0] rsp_r, rsp_r2;
  logic         eng_go, eng_mode, eng_done;
  logic [W-1:0] eng_n, eng_r;

  int checks = 0;
  int errors = 0;
  int go_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0;
  bit go_prev = 0, hang = 0, e_pend = 0, drop0 = 0, drop1 = 0;
  int e_cyc = 0, e_dly = 0;
  logic         mode_log[$];
  logic [W-1:0] ngo_log[$];
  bit           m_cv = 0;
  logic [W-1:0] m_cn = '0;
  int           m_ptr = 0;
  logic [W-1:0] l_r, l_r2;
  logic         l_id, l_err;
  int           l_ord[2];
  logic [W-1:0] pool[4];

  mod_precomp_sched #(.W(W), .TMO(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_r2     (rsp_r2),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .eng_go     (eng_go),
    .eng_mode   (eng_mode),
    .eng_n      (eng_n),
    .eng_r      (eng_r),
    .eng_done   (eng_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] n);
    longint unsigned x;
    x = 64'h1_0000 % longint'(n);
    return W'(x);
  endfunction

  function automatic logic [W-1:0] ref_r2(input logic [W-1:0] n);
    longint unsigned x;
    x = 64'h1_0000_0000 % longint'(n);
    return W'(x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine: keeps the previous done level for two cycles after go, then
  // answers after a random delay using whatever mode/n it sees at that time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_ready) rdy0_cnt++;
      if (req1_ready) rdy1_cnt++;
      if (eng_go) begin
        checks++;
        assert (!go_prev) else begin
          errors++;
          $error("FAIL eng_go_width observed=2 expected=1");
        end
        go_cnt++;
        mode_log.push_back(eng_mode);
        ngo_log.push_back(eng_n);
        e_pend = 1;
        e_cyc  = 0;
        e_dly  = $urandom_range(4, 8);
      end else if (e_pend) begin
        e_cyc++;
        if (e_cyc == 3) begin
          eng_done = 1'b0;
          if (hang) e_pend = 0;
        end
        if (e_pend && e_cyc == e_dly) begin
          eng_r    = eng_mode ? ref_r2(eng_n) : ref_r(eng_n);
          eng_done = 1'b1;
          e_pend   = 0;
        end
      end
      go_prev = eng_go;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (drop0) begin req0_valid = 1'b0; drop0 = 0; end
    if (drop1) begin req1_valid = 1'b0; drop1 = 0; end
    if (req0_ready) drop0 = 1;
    if (req1_ready) drop1 = 1;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctrl"}, {57'b0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, eng_go, eng_mode}, 64'd0);
    chk({tag, "_data"}, {16'b0, rsp_r, rsp_r2, eng_n}, 64'd0);
  endtask

  task automatic serve(input bit v0, input bit v1, input logic [W-1:0] n0,
                       input logic [W-1:0] n1, input int hold);
    int nsrv, go_base, r0b, r1b, lat, gstep, ngo;
    int e_id[2];
    bit e_hit[2], e_err[2], got;
    logic [W-1:0] e_r[2], e_r2[2], nk;
    logic e_md[4];
    logic [W-1:0] e_ng[4];
    nsrv    = (v0 && v1) ? 2 : 1;
    e_id[0] = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
    e_id[1] = 1 - e_id[0];
    ngo     = 0;
    for (int k = 0; k < nsrv; k++) begin
      nk       = e_id[k] ? n1 : n0;
      e_hit[k] = m_cv && (m_cn == nk);
      m_ptr    = 1 - m_ptr;
      if (e_hit[k]) begin
        e_err[k] = 0; e_r[k] = ref_r(nk); e_r2[k] = ref_r2(nk);
      end else if (hang) begin
        e_err[k] = 1; e_r[k] = '0; e_r2[k] = '0; m_cv = 0;
        e_md[ngo] = 1'b0; e_ng[ngo] = nk; ngo++;
      end else begin
        e_err[k] = 0; e_r[k] = ref_r(nk); e_r2[k] = ref_r2(nk);
        m_cv = 1; m_cn = nk;
        e_md[ngo] = 1'b0; e_ng[ngo] = nk; ngo++;
        e_md[ngo] = 1'b1; e_ng[ngo] = nk; ngo++;
      end
    end
    go_base = go_cnt; r0b = rdy0_cnt; r1b = rdy1_cnt;
    req0_n = n0; req1_n = n1;
    req0_valid = v0; req1_valid = v1;
    lat = 0; gstep = -1;
    for (int k = 0; k < nsrv; k++) begin
      got = 0;
      for (int s = 0; s < 400 && !got; s++) begin
        tick();
        lat++;
        if (gstep < 0 && go_cnt > go_base) gstep = lat;
        if (rsp_valid) got = 1;
      end
      chk("rsp_arrives", 64'(got), 64'd1);
      if (!got) break;
      chk("rsp_id", 64'(rsp_id), 64'(e_id[k]));
      chk("rsp_r", 64'(rsp_r), 64'(e_r[k]));
      chk("rsp_r2", 64'(rsp_r2), 64'(e_r2[k]));
      chk("rsp_err", 64'(rsp_err), 64'(e_err[k]));
      l_ord[k] = int'(rsp_id); l_id = rsp_id; l_r = rsp_r; l_r2 = rsp_r2; l_err = rsp_err;
      if (k == 0 && e_hit[0]) chk("hit_latency", 64'(lat), 64'd2);
      if (e_err[k]) chk("tmo_latency", 64'((lat - gstep >= 100) && (lat - gstep <= 102)), 64'd1);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("rsp_hold", {27'b0, rsp_valid, rsp_id, rsp_err, rsp_r, rsp_r2, req0_ready, req1_ready},
            {27'b0, 1'b1, l_id, l_err, l_r, l_r2, 2'b00});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    tick();
    tick();
    chk("go_count", 64'(go_cnt - go_base), 64'(ngo));
    for (int i = 0; i < ngo && i < go_cnt - go_base; i++) begin
      chk("go_mode", 64'(mode_log[go_base + i]), 64'(e_md[i]));
      chk("go_n", 64'(ngo_log[go_base + i]), 64'(e_ng[i]));
    end
    chk("rdy0_pulses", 64'(rdy0_cnt - r0b), 64'(v0));
    chk("rdy1_pulses", 64'(rdy1_cnt - r1b), 64'(v1));
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_n = '0; req1_n = '0;
    rsp_ready = 1'b0;
    eng_done = 1'b0; eng_r = '0;
    pool[0] = 16'h00B3; pool[1] = 16'h1001; pool[2] = 16'h7FFF; pool[3] = 16'hFFF1;
    repeat (2) @(negedge clk);
    #1;
    chk_outs_zero("reset");
    rst_n = 1'b1;
    tick();

    // first request misses and runs both engine operations
    serve(1, 0, 16'h00B3, 16'h0000, 0);
    chk("b3_r", 64'(l_r), 64'h0016);
    chk("b3_r2", 64'(l_r2), 64'h007E);
    chk("b3_id", 64'(l_id), 64'd0);

    // same modulus from the other requester hits the cache
    serve(0, 1, 16'h0000, 16'h00B3, 0);
    chk("hit_r", 64'(l_r), 64'h0016);
    chk("hit_r2", 64'(l_r2), 64'h007E);
    chk("hit_id", 64'(l_id), 64'd1);

    // simultaneous requests, distinct moduli
    serve(1, 1, 16'h0101, 16'h0F0F, 0);
    chk("both_first", 64'(l_ord[0]), 64'd0);
    chk("both_second", 64'(l_ord[1]), 64'd1);

    // consumer stalls for ten cycles
    serve(1, 0, 16'h00B3, 16'h0000, 10);

    // engine never finishes
    hang = 1;
    serve(0, 1, 16'h0000, 16'h2345, 0);
    hang = 0;
    chk("tmo_err", 64'(l_err), 64'd1);
    serve(0, 1, 16'h0000, 16'h2345, 0);

    // reset during the second engine operation
    base = go_cnt;
    req0_n = 16'h1234;
    req0_valid = 1'b1;
    for (int s = 0; s < 100 && go_cnt < base + 2; s++) tick();
    chk("rst_reach_t", 64'(go_cnt - base), 64'd2);
    tick();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drop0 = 0; drop1 = 0;
    eng_done = 1'b0; e_pend = 0; go_prev = 0;
    #1;
    chk_outs_zero("midjob_reset");
    m_cv = 0; m_ptr = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    serve(1, 0, 16'h1234, 16'h0000, 0);

    for (int t = 0; t < 14; t++) begin
      int p;
      logic [W-1:0] a, b;
      p = $urandom_range(1, 3);
      a = ($urandom_range(0, 4) == 4) ? W'($urandom_range(3, 16'hFFFF)) : pool[$urandom_range(0, 3)];
      b = ($urandom_range(0, 4) == 4) ? W'($urandom_range(3, 16'hFFFF)) : pool[$urandom_range(0, 3)];
      serve(p[0], p[1], a, b, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_precomp_sched.md
MOD_PRECOMP_SCHED -- requirements
Module: mod_precomp_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  W  4096  modulus/result width in bits
  TMO  1048575  max cycles waited per engine operation before error
REQ-002 Ports SHALL be (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  req0_valid / req1_valid  in  1  requester 0/1 asks for precompute of its modulus
  req0_n / req1_n  in  W  modulus n of requester 0/1, stable while valid
  req0_ready / req1_ready  out  1  request accepted this cycle
  rsp_valid  out  1  result available
  rsp_id  out  1  requester the result belongs to
  rsp_r  out  W  R mod n, R = 2^W
  rsp_r2  out  W  R^2 mod n
  rsp_err  out  1  engine timed out; rsp_r/rsp_r2 are zero
  rsp_ready  in  1  consumer takes the result
  eng_go  out  1  one-cycle start pulse to the modulus engine
  eng_mode  out  1  0 = compute R mod n, 1 = compute R^2 mod n
  eng_n  out  W  modulus driven to the engine
  eng_r  in  W  engine result
  eng_done  in  1  engine finished; level, held until the next go
REQ-003 Clock and reset SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-004 States SHALL be IDLE, ARB, GO_R, WAIT_R, GO_T, WAIT_T, RESP.
REQ-005 IDLE->ARB when any reqX_valid; arbitration SHALL be round-robin, pointer starting at 0 and toggling after each grant; a lone requester SHALL always win.
REQ-006 Grant SHALL pulse the winner's reqX_ready for exactly one cycle in ARB and latch n and id; the other ready stays 0.
REQ-007 Cache SHALL hold one entry (valid, n, r, r2); granted n equal to the cached n with valid=1 SHALL go ARB->RESP, rsp_valid asserted the next cycle.
REQ-008 On a miss, GO_R SHALL assert eng_go=1, eng_mode=0, eng_n=n for one cycle; eng_mode/eng_n SHALL stay stable through WAIT_R.
REQ-009 WAIT_R and WAIT_T SHALL ignore eng_done for the first 2 cycles after eng_go (stale level from the previous job), then capture eng_r on the first eng_done=1.
REQ-010 WAIT_R->GO_T->WAIT_T SHALL repeat with eng_mode=1; on completion, r and r2 SHALL be written to the cache (valid=1) and the FSM SHALL enter RESP.
REQ-011 A per-operation cycle counter SHALL reach TMO without eng_done -> RESP with rsp_err=1, zero data, cache invalidated.
REQ-012 RESP SHALL hold rsp_valid and all rsp_* stable until rsp_valid&&rsp_ready, then return to IDLE in that cycle; no new grant while in RESP.
REQ-013 Minimum latency: hit = 2 cycles from reqX_valid to rsp_valid; miss = engine time + 6 cycles.
REQ-014 eng_go SHALL never assert outside GO_R/GO_T; at most one engine job SHALL be outstanding.

Reset
REQ-015 rst_n low SHALL asynchronously force IDLE, all outputs 0, cache valid=0, RR pointer=0, counter=0.
REQ-016 Reset mid-job SHALL abandon the job silently; after release the first request SHALL miss.

Structure
REQ-017 State encoding, mode constants (OP_R=0, OP_T=1) and the default W/TMO SHALL live in a shared package, rsa_pkg.
REQ-018 Arbitration SHALL be a sub-module rr_arb2 (2 requesters, rotating pointer); cache and FSM stay in the top.

Verification (W=16 bench override, behavioural engine, n=0x00B3 -> r=0x0016, r2=0x007E)
REQ-019 req0 n=0x00B3 after reset -> eng_go twice (mode 0 then 1), rsp id=0 r=0x0016 r2=0x007E err=0.
REQ-020 Repeat req1 n=0x00B3 -> no eng_go, rsp_valid 2 cycles after valid, same values, id=1.
REQ-021 req0 and req1 valid in the same cycle with distinct n -> req0 served first, then req1; each ready pulses once.
REQ-022 Engine never asserts done, TMO=100 -> rsp_err=1 at cycle ~101 of WAIT_R, data 0, next same-n request misses.
REQ-023 rst_n low during WAIT_T -> outputs 0 immediately; new request re-runs both engine ops.
REQ-024 rsp_ready held low 10 cycles -> rsp_* stable, no ready pulses to requesters until handshake.
